pipe_credit_sink: RTL and testbench



---
 rtl/pipe_credit_sink_if.sv | 23 ++
 rtl/pipe_credit_sink.sv | 112 +++++++++++
 tb/tb_pipe_credit_sink.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_credit_sink_if.sv
// Handshake bundle for pipe_credit_sink: credit/issue toward the pipeline head,
// tail input, and the downstream valid/ready port. The sink uses the slave modport.
interface pipe_credit_sink_if #(
  parameter int unsigned WIDTH = 32
);
  logic             issue_ok;
  logic             issue;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    input  issue_ok, out_valid, out_data,
    output issue, in_valid, in_data, out_ready
  );

  modport slave (
    output issue_ok, out_valid, out_data,
    input  issue, in_valid, in_data, out_ready
  );
endinterface

// File: rtl/pipe_credit_sink.sv
// Credit-based tail receiver for a fixed-latency, non-stallable pipeline.
// Define PIPE_CREDIT_SINK_ERR_EN to enable the sticky err flags.
module pipe_credit_sink #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned LATENCY = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pipe_credit_sink_if.slave      bus,
  output logic [$clog2(DEPTH):0] count,
  output logic [1:0]             err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("pipe_credit_sink: DEPTH must be a power of two and at least 2");
  end
  if (DEPTH < LATENCY + 1) begin : g_bad_latency
    $error("pipe_credit_sink: DEPTH must be at least LATENCY+1 for full throughput");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    reserved_q, reserved_d;
  logic             out_valid;
  logic             full;
  logic             pop;
  logic             push;

  assign out_valid     = (count_q != '0);
  assign full          = (count_q == DepthC);
  assign pop           = out_valid && bus.out_ready;
  // A full FIFO still takes a word when the same cycle frees a slot.
  assign push          = bus.in_valid && (!full || pop);

  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_valid ? mem[rd_ptr_q] : '0;
  assign bus.issue_ok  = (reserved_q < DepthC);
  assign count         = count_q;

  always_comb begin
    reserved_d = reserved_q;
    case ({bus.issue, pop})
      2'b10:   if (reserved_q != DepthC) reserved_d = reserved_q + 1'b1;
      // Floor at zero so stale post-reset tail words cannot wrap the credit count.
      2'b01:   if (reserved_q != '0) reserved_d = reserved_q - 1'b1;
      default: reserved_d = reserved_q;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      reserved_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      reserved_q <= reserved_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= bus.in_data;
  end

`ifdef PIPE_CREDIT_SINK_ERR_EN
  logic [1:0] err_q;
  logic       err_no_credit;
  logic       err_overflow;

  assign err_no_credit = bus.issue && !bus.issue_ok;
  assign err_overflow  = bus.in_valid && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 2'b00;
    end else begin
      err_q <= err_q | {err_overflow, err_no_credit};
    end
  end

  assign err = err_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n && err_no_credit) $error("pipe_credit_sink: issue without credit");
    if (rst_n && err_overflow)  $error("pipe_credit_sink: push into full FIFO dropped");
  end
`endif
`else
  assign err = 2'b00;
`endif

endmodule

// File: tb/tb_pipe_credit_sink.sv
// Scoreboard bench for pipe_credit_sink: models the 4-stage upstream pipeline,
// queues expected words at issue time and checks them as the DUT pops.
module tb_pipe_credit_sink;
  localparam int unsigned WIDTH   = 32;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned LATENCY = 4;
  localparam int unsigned CW      = $clog2(DEPTH) + 1;
  typedef logic [CW-1:0] cnt_t;

`ifdef PIPE_CREDIT_SINK_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CW-1:0] count;
  logic [1:0]    err;

  pipe_credit_sink_if #(.WIDTH(WIDTH)) bus ();

  pipe_credit_sink #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .LATENCY(LATENCY)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .count(count),
    .err  (err)
  );

  always #5 clk = ~clk;

  int               n_cmp = 0;
  int               n_fail = 0;
  logic [WIDTH-1:0] sb [$];
  logic             pv [LATENCY];
  logic [WIDTH-1:0] pd [LATENCY];
  logic [WIDTH-1:0] issue_data;
  logic [WIDTH-1:0] exp_w;
  logic             prev_iv;
  int               n_iss;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance one cycle and shift the upstream pipeline model.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = LATENCY - 1; i > 0; i--) begin
      pv[i] = pv[i-1];
      pd[i] = pd[i-1];
    end
    pv[0]        = bus.issue;
    pd[0]        = issue_data;
    bus.issue    = 1'b0;
    bus.in_valid = pv[LATENCY-1];
    bus.in_data  = pd[LATENCY-1];
  endtask

  task automatic issue_word(input logic [WIDTH-1:0] d, input bit keep);
    bus.issue  = 1'b1;
    issue_data = d;
    if (keep) sb.push_back(d);
  endtask

  task automatic wait_count(input cnt_t target, input int budget, input string name);
    int n = 0;
    while (count != target && n < budget) begin
      tick();
      n++;
    end
    check(name, 64'(count), 64'(target));
  endtask

  // Monitor: each accepted output word must match the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL out_word: got %0h, expected no word", bus.out_data);
      end else begin
        exp_w = sb.pop_front();
        if (bus.out_data !== exp_w) begin
          n_fail++;
          $display("FAIL out_word: got %0h, expected %0h", bus.out_data, exp_w);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.issue     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    issue_data    = '0;
    for (int i = 0; i < LATENCY; i++) begin
      pv[i] = 1'b0;
      pd[i] = '0;
    end

    // Reset then idle
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check("reset_issue_ok",  64'(bus.issue_ok),  64'(1));
    check("reset_out_valid", 64'(bus.out_valid), 64'(0));
    check("reset_count",     64'(count),         64'(0));
    check("reset_err",       64'(err),           64'(0));
    check("reset_out_data",  64'(bus.out_data),  64'(0));

    // Streaming: 20 back-to-back words, output one cycle after in_valid
    bus.out_ready = 1'b1;
    prev_iv = 1'b0;
    for (int k = 0; k < 20 + LATENCY + 2; k++) begin
      if (k < 20) issue_word(WIDTH'(k), 1'b1);
      check("stream_issue_ok",  64'(bus.issue_ok),        64'(1));
      check("stream_count_le1", 64'(count <= cnt_t'(1)), 64'(1));
      check("stream_latency",   64'(bus.out_valid),       64'(prev_iv));
      prev_iv = bus.in_valid;
      tick();
    end
    check("stream_empty", 64'(count), 64'(0));

    // Stall: credits run out after exactly DEPTH issues
    bus.out_ready = 1'b0;
    n_iss = 0;
    for (int k = 0; k < 12 && bus.issue_ok; k++) begin
      issue_word(WIDTH'(100 + k), 1'b1);
      n_iss++;
      tick();
    end
    check("stall_issues",      64'(n_iss),        64'(8));
    check("stall_issue_ok_lo", 64'(bus.issue_ok), 64'(0));
    wait_count(cnt_t'(8), 10, "stall_count_full");
    check("stall_front", 64'(bus.out_data), 64'(100));
    tick();
    check("stall_front_stable", 64'(bus.out_data), 64'(100));
    bus.out_ready = 1'b1;
    check("no_early_credit", 64'(bus.issue_ok), 64'(0));
    tick();
    check("credit_after_pop", 64'(bus.issue_ok), 64'(1));
    wait_count(cnt_t'(0), 12, "stall_drain");

    // Three more words put the write pointer on the last slot
    for (int k = 0; k < 3; k++) begin
      issue_word(WIDTH'(200 + k), 1'b1);
      tick();
    end
    repeat (LATENCY + 2) tick();
    check("align_empty", 64'(count), 64'(0));

    // Fill, then push and pop together while full; write wraps to slot 0
    bus.out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      issue_word(WIDTH'(300 + k), 1'b1);
      tick();
    end
    wait_count(cnt_t'(8), 10, "wrap_fill");
    bus.in_valid  = 1'b1;
    bus.in_data   = 308;
    sb.push_back(308);
    bus.out_ready = 1'b1;
    tick();
    check("pushpop_full_count", 64'(count), 64'(8));
    wait_count(cnt_t'(0), 12, "wrap_drain");

    // Error cases: issue without credit, then that word hits a full FIFO
    bus.out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      issue_word(WIDTH'(400 + k), 1'b1);
      tick();
    end
    check("err_pre_issue_ok", 64'(bus.issue_ok), 64'(0));
    issue_word(408, 1'b0);
    tick();
    check("err_no_credit", 64'(err[0]), 64'(ErrEn));
    check("err_sat_issue_ok", 64'(bus.issue_ok), 64'(0));
    wait_count(cnt_t'(8), 10, "err_fill");
    check("err_tail_valid", 64'(bus.in_valid), 64'(1));
    tick();
    check("err_drop_count", 64'(count),  64'(8));
    check("err_overflow",   64'(err[1]), 64'(ErrEn));
    check("err_sticky0",    64'(err[0]), 64'(ErrEn));
    bus.out_ready = 1'b1;
    wait_count(cnt_t'(0), 12, "err_drain");
    check("err_held", 64'(err), 64'({ErrEn, ErrEn}));
    check("err_credit_back", 64'(bus.issue_ok), 64'(1));

    // Async reset mid-burst with five words buffered
    bus.out_ready = 1'b0;
    for (int n = 0; n < 20 && count != cnt_t'(5); n++) begin
      if (bus.issue_ok) issue_word(WIDTH'(500 + n), 1'b1);
      tick();
    end
    check("burst_count", 64'(count), 64'(5));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_out_valid", 64'(bus.out_valid), 64'(0));
    check("async_count",     64'(count),         64'(0));
    check("async_issue_ok",  64'(bus.issue_ok),  64'(1));
    check("async_err",       64'(err),           64'(0));
    sb.delete();
    repeat (LATENCY + 2) tick();
    rst_n = 1'b1;
    tick();
    check("post_reset_count", 64'(count), 64'(0));

    // Recovery after reset
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      issue_word(WIDTH'(600 + k), 1'b1);
      tick();
    end
    repeat (LATENCY + 3) tick();
    check("final_count",    64'(count),     64'(0));
    check("final_sb_empty", 64'(sb.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
